// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states, ALU codes.
// Latency: none. This file holds declarations only.
// Backpressure: not applicable; imported by the FSM top and the ALU decoder.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode alone, independent of FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decoder: ALUOp plus instruction funct fields to a 3-bit ALUControl.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module mc_alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  // Fixed add/sub for address and compare work; funct-driven decode for R/I arithmetic.
  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (Op[5]=1) can ask for sub; addi ignores funct7.
          3'b000:  alu_control = (op_5 && funct7_5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alu_control = ALUC_SLT;
          3'b110:  alu_control = ALUC_OR;
          3'b111:  alu_control = ALUC_AND;
          default: alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM driving datapath muxes/enables through a shared ALU and unified memory.
// Latency: 3-5 cycles per instruction with zero-wait memory; each mem_ready-low cycle adds one.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold state and outputs until mem_ready; TRAP is sticky until reset.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned ENABLE_BNE = 1,
  parameter int unsigned STATE_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            Op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  instr_done,
  output logic                  illegal,
  output logic [STATE_W-1:0]    state_dbg
);

  state_e     state_q, state_d;
  logic       branch_ok;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl3;
  logic       mem_req_m, mem_write_m, ir_write_m, pc_write_m;
  logic       reg_write_m, instr_done_m, illegal_m;
  logic       unused_funct7;

  // Only funct7[5] (sub vs add) matters to this control path.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // beq is always legal; bne only when built in.
  assign branch_ok = (funct3 == 3'b000) || ((funct3 == 3'b001) && (ENABLE_BNE != 0));

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state sequencing; memory states wait on mem_ready, TRAP only leaves via reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = branch_ok ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:     state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH:  state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // Per-state control decode; FETCH/MEMWRITE strobes and the branch PC write also see mem_ready/Zero.
  always_comb begin
    mem_req_m    = 1'b0;
    mem_write_m  = 1'b0;
    AdrSrc       = 1'b0;
    ir_write_m   = 1'b0;
    pc_write_m   = 1'b0;
    reg_write_m  = 1'b0;
    instr_done_m = 1'b0;
    illegal_m    = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    alu_op       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_m  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_m = mem_ready;
        pc_write_m = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_m = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        reg_write_m  = 1'b1;
        instr_done_m = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_m    = 1'b1;
        mem_write_m  = 1'b1;
        AdrSrc       = 1'b1;
        instr_done_m = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_m  = 1'b1;
        instr_done_m = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        alu_op       = ALUOP_SUB;
        instr_done_m = 1'b1;
        if (funct3 == 3'b000)      pc_write_m = Zero;
        else if (funct3 == 3'b001) pc_write_m = !Zero;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_m = 1'b1;
      end
      S_TRAP:  illegal_m = 1'b1;
      default: illegal_m = 1'b0;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .op_5        (Op[5]),
    .alu_control (alu_ctrl3)
  );

  // Enables are suppressed while reset is held so nothing is written during or across it.
  assign mem_req    = mem_req_m    & rst;
  assign MemWrite   = mem_write_m  & rst;
  assign IRWrite    = ir_write_m   & rst;
  assign PCWrite    = pc_write_m   & rst;
  assign RegWrite   = reg_write_m  & rst;
  assign instr_done = instr_done_m & rst;
  assign illegal    = illegal_m    & rst;

  assign ImmSrc     = imm_src_of(Op);
  assign ALUControl = ALU_CTRL_W'(alu_ctrl3);
  assign state_dbg  = STATE_W'(state_q);

endmodule
